// File: rtl/hazard_unit_pipe_pkg.sv
// rtl/hazard_unit_pipe_pkg.sv - shared pipeline constants and forward-select type
package hazard_unit_pipe_pkg;

   // Result-source encodings seen on resultsrcE
   localparam logic [1:0] RESULT_ALU = 2'b00;
   localparam logic [1:0] RESULT_MEM = 2'b01;
   localparam logic [1:0] RESULT_PC4 = 2'b10;

   // Operand forward select driven to the EX-stage muxes
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwdSel_t;

endpackage

// File: rtl/hazard_perf_counters.sv
// rtl/hazard_perf_counters.sv - wrap-around stall/flush event counters
module hazard_perf_counters #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stallD_i,
   input  logic             flushD_i,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
);

   // Count cycles with each event; natural overflow gives modulo 2^CNT_W
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (stallD_i) stallCnt <= stallCnt + 1'b1;
         if (flushD_i) flushCnt <= flushCnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_unit_pipe.sv
// rtl/hazard_unit_pipe.sv - forwarding/stall/flush hazard unit (optional HAZARD_PERF_CNT_EN counters)
module hazard_unit_pipe
   import hazard_unit_pipe_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] rs1D_i,
   input  logic [REG_AW-1:0] rs2D_i,
   input  logic [REG_AW-1:0] rs1E_i,
   input  logic [REG_AW-1:0] rs2E_i,
   input  logic [REG_AW-1:0] rdE_i,
   input  logic              regwriteE_i,
   input  logic [1:0]        resultsrcE_i,
   input  logic              jumpE_i,
   input  logic              branchE_i,
   input  logic              zeroE_i,
   output logic [1:0]        forwardAE_o,
   output logic [1:0]        forwardBE_o,
   output logic              stallF_o,
   output logic              stallD_o,
   output logic              flushD_o,
   output logic              flushE_o,
   output logic              pcsrcE_o,
   output logic [REG_AW-1:0] rdM_o,
   output logic [REG_AW-1:0] rdW_o,
   output logic              regwriteM_o,
`ifdef HAZARD_PERF_CNT_EN
   output logic              regwriteW_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
`else
   output logic              regwriteW_o
`endif
);

   logic lwStall;
   logic pcsrc;

   // MEM/WB destination tracking; never stalled since a stall feeds a bubble into EX
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rdM_o       <= '0;
         regwriteM_o <= 1'b0;
         rdW_o       <= '0;
         regwriteW_o <= 1'b0;
      end else begin
         rdM_o       <= rdE_i;
         regwriteM_o <= regwriteE_i;
         rdW_o       <= rdM_o;
         regwriteW_o <= regwriteM_o;
      end
   end

   function automatic fwdSel_t fwdSelect(input logic [REG_AW-1:0] rs);
      if (regwriteM_o && (rdM_o != '0) && (rdM_o == rs))
         return FWD_MEM;
      else if (regwriteW_o && (rdW_o != '0) && (rdW_o == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   // Forward selects: MEM result is newer than WB, so it takes priority; x0 never forwards
   always_comb begin
      forwardAE_o = fwdSelect(rs1E_i);
      forwardBE_o = fwdSelect(rs2E_i);
   end

   // Load-use detection and control redirect; a taken redirect squashes ID so no stall is needed
   always_comb begin
      lwStall  = (resultsrcE_i == RESULT_MEM) && regwriteE_i && (rdE_i != '0) &&
                 ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
      pcsrc    = jumpE_i | (branchE_i & zeroE_i);
      stallF_o = rst_i & lwStall & ~pcsrc;
      stallD_o = rst_i & lwStall & ~pcsrc;
      flushD_o = rst_i & pcsrc;
      flushE_o = rst_i & (lwStall | pcsrc);
      pcsrcE_o = rst_i & pcsrc;
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counters #(
      .CNT_W (CNT_W)
   ) uPerf (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .stallD_i (stallD_o),
      .flushD_i (flushD_o),
      .stallCnt (stall_cnt_o),
      .flushCnt (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_hazard_unit_pipe.sv
// tb/tb_hazard_unit_pipe.sv - self-checking bench for hazard_unit_pipe
module tb_hazard_unit_pipe;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [4:0] rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i;
   logic       regwriteE_i;
   logic [1:0] resultsrcE_i;
   logic       jumpE_i, branchE_i, zeroE_i;
   logic [1:0] forwardAE_o, forwardBE_o;
   logic       stallF_o, stallD_o, flushD_o, flushE_o, pcsrcE_o;
   logic [4:0] rdM_o, rdW_o;
   logic       regwriteM_o, regwriteW_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

   int checks = 0;
   int passes = 0;

   // Reference history: index 0 = instruction that left EX last cycle, 1 = the one before
   logic [4:0] histRd[2];
   logic       histWe[2];

   hazard_unit_pipe #(.REG_AW(5), .CNT_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rs1D_i(rs1D_i), .rs2D_i(rs2D_i), .rs1E_i(rs1E_i), .rs2E_i(rs2E_i),
      .rdE_i(rdE_i), .regwriteE_i(regwriteE_i), .resultsrcE_i(resultsrcE_i),
      .jumpE_i(jumpE_i), .branchE_i(branchE_i), .zeroE_i(zeroE_i),
      .forwardAE_o(forwardAE_o), .forwardBE_o(forwardBE_o),
      .stallF_o(stallF_o), .stallD_o(stallD_o), .flushD_o(flushD_o),
      .flushE_o(flushE_o), .pcsrcE_o(pcsrcE_o),
      .rdM_o(rdM_o), .rdW_o(rdW_o),
`ifdef HAZARD_PERF_CNT_EN
      .regwriteM_o(regwriteM_o), .regwriteW_o(regwriteW_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`else
      .regwriteM_o(regwriteM_o), .regwriteW_o(regwriteW_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [4:0] rs1D, rs2D, rdE;
      logic       we;
      logic [1:0] rsrc;
      logic       jmp, br, zr;
      logic       eStall, eFlushD, eFlushE, ePc;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   task automatic idle();
      rs1D_i = 0; rs2D_i = 0; rs1E_i = 0; rs2E_i = 0; rdE_i = 0;
      regwriteE_i = 0; resultsrcE_i = 0; jumpE_i = 0; branchE_i = 0; zeroE_i = 0;
   endtask

   task automatic clearHist();
      for (int i = 0; i < 2; i++) begin histRd[i] = 0; histWe[i] = 0; end
   endtask

   // Advance one clock; history records what was in EX at the edge
   task automatic tick();
      @(posedge clk_i);
      histRd[1] = histRd[0]; histWe[1] = histWe[0];
      histRd[0] = rdE_i;     histWe[0] = regwriteE_i;
      @(negedge clk_i);
   endtask

   // Newest write to a nonzero rs wins; 2 = from MEM (age 0), 1 = from WB (age 1)
   function automatic logic [1:0] refFwd(input logic [4:0] rs);
      for (int age = 0; age < 2; age++)
         if (rs != 0 && histWe[age] && histRd[age] == rs) return 2'(2 - age);
      return 2'd0;
   endfunction

   task automatic chkCtl(input string nm, input logic st, input logic fd, input logic fe, input logic pc);
      chk({nm, ".stallF"}, 32'(stallF_o), 32'(st));
      chk({nm, ".stallD"}, 32'(stallD_o), 32'(st));
      chk({nm, ".flushD"}, 32'(flushD_o), 32'(fd));
      chk({nm, ".flushE"}, 32'(flushE_o), 32'(fe));
      chk({nm, ".pcsrc"},  32'(pcsrcE_o), 32'(pc));
   endtask

   initial begin
      logic ld, pc;
      vecs[0] = '{0,0,0,0,2'b00,0,0,0, 0,0,0,0};
      vecs[1] = '{3,0,3,1,2'b01,0,0,0, 1,0,1,0};
      vecs[2] = '{0,0,0,1,2'b01,0,0,0, 0,0,0,0};
      vecs[3] = '{3,0,3,0,2'b01,0,0,0, 0,0,0,0};
      vecs[4] = '{3,0,3,1,2'b00,0,0,0, 0,0,0,0};
      vecs[5] = '{0,0,0,0,2'b00,0,1,1, 0,1,1,1};
      vecs[6] = '{0,0,0,0,2'b00,0,1,0, 0,0,0,0};
      vecs[7] = '{0,0,0,0,2'b00,1,0,0, 0,1,1,1};
      vecs[8] = '{0,9,9,1,2'b01,1,0,0, 0,1,1,1};
      vecs[9] = '{6,0,6,1,2'b10,0,0,0, 0,0,0,0};

      // Reset state
      idle(); rst_i = 0; clearHist();
      #2;
      chk("rst.rdM", 32'(rdM_o), 0);
      chk("rst.rdW", 32'(rdW_o), 0);
      chk("rst.weM", 32'(regwriteM_o), 0);
      chk("rst.weW", 32'(regwriteW_o), 0);
      chk("rst.fwdA", 32'(forwardAE_o), 0);
      chk("rst.fwdB", 32'(forwardBE_o), 0);
      @(negedge clk_i); rst_i = 1;
      @(negedge clk_i);

      // Table-driven control vectors (rs1E = rs2E = 0 so forwarding stays 00)
      for (int i = 0; i < 10; i++) begin
         idle();
         rs1D_i = vecs[i].rs1D; rs2D_i = vecs[i].rs2D; rdE_i = vecs[i].rdE;
         regwriteE_i = vecs[i].we; resultsrcE_i = vecs[i].rsrc;
         jumpE_i = vecs[i].jmp; branchE_i = vecs[i].br; zeroE_i = vecs[i].zr;
         #1;
         chkCtl($sformatf("vec%0d", i), vecs[i].eStall, vecs[i].eFlushD, vecs[i].eFlushE, vecs[i].ePc);
         chk($sformatf("vec%0d.fwdA", i), 32'(forwardAE_o), 0);
         tick();
      end

      // RAW from MEM then WB
      idle(); rdE_i = 5; regwriteE_i = 1; tick();
      idle(); rs1E_i = 5; #1; chk("raw.fwdA_mem", 32'(forwardAE_o), 2);
      chk("raw.rdM", 32'(rdM_o), 5);
      tick();
      idle(); rs2E_i = 5; #1; chk("raw.fwdB_wb", 32'(forwardBE_o), 1);
      chk("raw.rdW", 32'(rdW_o), 5);
      tick();

      // Double hazard: MEM priority, and x0 never forwarded
      idle(); rdE_i = 7; regwriteE_i = 1; tick(); tick();
      idle(); rs1E_i = 7; #1; chk("dbl.fwdA", 32'(forwardAE_o), 2);
      rdE_i = 0; regwriteE_i = 1; rs1E_i = 0; tick(); tick();
      idle(); #1; chk("x0.fwdA", 32'(forwardAE_o), 0);

      // Load-use lasts one cycle, bubble clears it
      idle(); resultsrcE_i = 2'b01; regwriteE_i = 1; rdE_i = 3; rs2D_i = 3; #1;
      chkCtl("lu", 1, 0, 1, 0);
      tick();
      idle(); rs2D_i = 3; rdE_i = 3; #1;
      chkCtl("lu_bubble", 0, 0, 0, 0);
      tick();

      // Reset mid-stream with x4 in flight and hazards active
      idle(); rdE_i = 4; regwriteE_i = 1; tick();
      #1; chk("pre_rst.rdM", 32'(rdM_o), 4);
      resultsrcE_i = 2'b01; rs1D_i = 4; jumpE_i = 1; rs1E_i = 4;
      rst_i = 0; #1;
      chkCtl("midrst", 0, 0, 0, 0);
      chk("midrst.rdM", 32'(rdM_o), 0);
      chk("midrst.fwdA", 32'(forwardAE_o), 0);
      @(negedge clk_i);
      idle(); rs1E_i = 4; rst_i = 1; clearHist(); #1;
      chk("postrst.fwdA", 32'(forwardAE_o), 0);
`ifdef HAZARD_PERF_CNT_EN
      chk("cnt.stall0", stall_cnt_o, 0);
      chk("cnt.flush0", flush_cnt_o, 0);
      for (int i = 0; i < 3; i++) begin
         idle(); resultsrcE_i = 2'b01; regwriteE_i = 1; rdE_i = 2; rs1D_i = 2;
         tick();
      end
      idle(); #1;
      chk("cnt.stall3", stall_cnt_o, 3);
      chk("cnt.flush3", flush_cnt_o, 0);
`endif
      tick();

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         rs1D_i = 5'($urandom_range(0, 7)); rs2D_i = 5'($urandom_range(0, 7));
         rs1E_i = 5'($urandom_range(0, 7)); rs2E_i = 5'($urandom_range(0, 7));
         rdE_i  = 5'($urandom_range(0, 7));
         regwriteE_i  = 1'($urandom_range(0, 1));
         resultsrcE_i = 2'($urandom_range(0, 3));
         jumpE_i   = ($urandom_range(0, 7) == 0);
         branchE_i = 1'($urandom_range(0, 1));
         zeroE_i   = 1'($urandom_range(0, 1));
         #1;
         ld = (resultsrcE_i == 2'b01) && regwriteE_i && rdE_i != 0 &&
              (rdE_i == rs1D_i || rdE_i == rs2D_i);
         pc = jumpE_i || (branchE_i && zeroE_i);
         chk("rnd.fwdA", 32'(forwardAE_o), 32'(refFwd(rs1E_i)));
         chk("rnd.fwdB", 32'(forwardBE_o), 32'(refFwd(rs2E_i)));
         chk("rnd.rdM", 32'({regwriteM_o, rdM_o}), 32'({histWe[0], histRd[0]}));
         chk("rnd.rdW", 32'({regwriteW_o, rdW_o}), 32'({histWe[1], histRd[1]}));
         chkCtl("rnd", ld && !pc, pc, ld || pc, pc);
         tick();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
